rle_pack: RTL and testbench

Downstream stage of the RLE encoder in the DSLogic capture path. Accepts the encoder's 16-bit tokens (bit 15 = 0: sample, bit 15 = 1: repeat count), packs them in pairs into 32-bit memory words and buffers them in a small FIFO. The FIFO is drained by the memory writer through a valid/ready handshake. Also manages the capture window: start, stop, a word limit, and a flush of a half-filled word.

---
 rtl/rle_pack_pkg.sv | 21 ++
 rtl/rle_pack_if.sv | 26 ++
 rtl/rle_pack_fifo.sv | 59 +++++
 rtl/rle_pack.sv | 141 ++++++++++++++
 tb/tb_rle_pack.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rle_pack_pkg.sv
// Shared types and constants for the RLE token packer.
package rle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } rle_state_e;

    localparam int          RLE_CNT_FLAG      = 15;
    localparam logic [15:0] PAD_TOKEN         = 16'(1 << RLE_CNT_FLAG);
    localparam logic [23:0] DEFAULT_MAX_WORDS = 24'h800000;

    // Second token lands in the upper half of the memory word.
    function automatic logic [31:0] pack_pair(input logic [15:0] second,
                                              input logic [15:0] first);
        return {second, first};
    endfunction

endpackage

// File: rtl/rle_pack_if.sv
// Token input and memory-writer handshake bundle for rle_pack.
interface rle_pack_if;

    logic [15:0] rle_data;
    logic        rle_valid;
    logic [31:0] mem_data;
    logic        mem_valid;
    logic        mem_ready;

    modport master (
        output rle_data,
        output rle_valid,
        output mem_ready,
        input  mem_data,
        input  mem_valid
    );

    modport slave (
        input  rle_data,
        input  rle_valid,
        input  mem_ready,
        output mem_data,
        output mem_valid
    );

endinterface

// File: rtl/rle_pack_fifo.sv
// First-word-fall-through FIFO of 32-bit packed words with synchronous clear.
module rle_pack_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [31:0]            din,
    output logic [31:0]            dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_CNT);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Empty head reads as zero so the output never shows stale storage.
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/rle_pack.sv
// Packs 16-bit RLE tokens in pairs into 32-bit words and manages the capture window.
// Define RLE_PACK_FLUSH_EN to pad and push a pending half word on flush instead of discarding it.
module rle_pack
    import rle_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [23:0] MAX_WORDS  = DEFAULT_MAX_WORDS
) (
    input  logic             core_clk,
    input  logic             core_rst,
    input  logic             start,
    input  logic             stop,
    rle_pack_if.slave        bus,
    output logic [23:0]      words_written,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    rle_state_e  state_q, state_d;
    logic [15:0] half_reg_q, half_reg_d;
    logic        half_pend_q, half_pend_d;
    logic [23:0] words_q, words_d;
    logic        overflow_q, overflow_d;

    logic        clear;
    logic        accept;
    logic        pair_push;
    logic        pad_push;
    logic        push_req;
    logic        push_ok;
    logic        pop;
    logic [31:0] push_word;
    logic [23:0] words_inc;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_full;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic        unused_count;

    assign pop       = bus.mem_valid && bus.mem_ready;
    assign accept    = (state_q == RUN) && bus.rle_valid;
    assign pair_push = accept && half_pend_q;

`ifdef RLE_PACK_FLUSH_EN
    assign pad_push  = (state_q == FLUSH) && half_pend_q;
`else
    assign pad_push  = 1'b0;
`endif

    assign push_req  = pair_push || pad_push;
    assign push_word = pair_push ? pack_pair(bus.rle_data, half_reg_q)
                                 : pack_pair(PAD_TOKEN, half_reg_q);
    // A full FIFO still takes a word when its head leaves in the same cycle.
    assign push_ok   = push_req && (!fifo_full || pop);
    assign words_inc = (words_q == MAX_WORDS) ? words_q : words_q + 24'd1;

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state_q     <= IDLE;
            half_reg_q  <= '0;
            half_pend_q <= 1'b0;
            words_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            half_reg_q  <= half_reg_d;
            half_pend_q <= half_pend_d;
            words_q     <= words_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        half_reg_d  = half_reg_q;
        half_pend_d = half_pend_q;
        words_d     = words_q;
        overflow_d  = overflow_q;
        clear       = 1'b0;

        if (push_ok)              words_d    = words_inc;
        if (push_req && !push_ok) overflow_d = 1'b1;

        if (accept) begin
            if (half_pend_q) begin
                half_pend_d = 1'b0;
            end else begin
                half_reg_d  = bus.rle_data;
                half_pend_d = 1'b1;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    clear       = 1'b1;
                    words_d     = '0;
                    overflow_d  = 1'b0;
                    half_reg_d  = '0;
                    half_pend_d = 1'b0;
                end
            end
            RUN: begin
                if (stop || (push_ok && words_inc == MAX_WORDS)) state_d = FLUSH;
            end
            FLUSH: begin
                // Any half word is either padded out or dropped on the first flush cycle.
                half_pend_d = 1'b0;
                if (!half_pend_q && fifo_empty) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    rle_pack_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (core_clk),
        .rst   (core_rst),
        .clear (clear),
        .push  (push_ok),
        .pop   (pop),
        .din   (push_word),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign unused_count  = ^fifo_count;

    assign bus.mem_data  = fifo_dout;
    assign bus.mem_valid = !fifo_empty;
    assign words_written = words_q;
    assign overflow      = overflow_q;
    assign busy          = (state_q == RUN) || (state_q == FLUSH);
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_rle_pack.sv
// Directed and randomized checks of rle_pack against a token-list reference model.
`timescale 1ns/1ps
module tb_rle_pack;
    import rle_pkg::*;

    localparam int          DEPTH = 16;
    localparam logic [23:0] LIM   = 24'd4;
    localparam int          BIG   = 1 << 30;
`ifdef RLE_PACK_FLUSH_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic        core_clk = 1'b0;
    logic        core_rst;
    logic        start, stop, tokValid, readyB, randReady;
    logic [15:0] tok;
    logic [23:0] wordsB, wordsL;
    logic        overflowB, overflowL, busyB, busyL, doneB, doneL;

    int total = 0;
    int bad   = 0;

    logic [31:0] gotB[$];
    logic [31:0] gotL[$];
    logic [31:0] expW[$];
    logic [15:0] sentTok[$];

    rle_pack_if ifcB();
    rle_pack_if ifcL();

    assign ifcB.rle_data  = tok;
    assign ifcB.rle_valid = tokValid;
    assign ifcB.mem_ready = readyB;
    assign ifcL.rle_data  = tok;
    assign ifcL.rle_valid = tokValid;
    assign ifcL.mem_ready = 1'b1;

    always #5 core_clk = ~core_clk;

    rle_pack #(.FIFO_DEPTH(DEPTH)) dutB (
        .core_clk      (core_clk),
        .core_rst      (core_rst),
        .start         (start),
        .stop          (stop),
        .bus           (ifcB),
        .words_written (wordsB),
        .overflow      (overflowB),
        .busy          (busyB),
        .done          (doneB)
    );

    rle_pack #(.FIFO_DEPTH(DEPTH), .MAX_WORDS(LIM)) dutL (
        .core_clk      (core_clk),
        .core_rst      (core_rst),
        .start         (start),
        .stop          (stop),
        .bus           (ifcL),
        .words_written (wordsL),
        .overflow      (overflowL),
        .busy          (busyL),
        .done          (doneL)
    );

    // Collect every word the memory writer accepts.
    always @(posedge core_clk) begin
        if (ifcB.mem_valid && ifcB.mem_ready) gotB.push_back(ifcB.mem_data);
        if (ifcL.mem_valid && ifcL.mem_ready) gotL.push_back(ifcL.mem_data);
    end

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] t, input logic v,
                                 input logic st, input logic sp);
        tok      = t;
        tokValid = v;
        start    = st;
        stop     = sp;
        if (randReady) readyB = 1'($urandom_range(0, 1));
        if (v) sentTok.push_back(t);
        tick();
        tok      = 16'h0;
        tokValid = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pair tokens in arrival order; stop at the word limit, drop words beyond capacity.
    function automatic void buildModel(input int limit, input int cap);
        logic [15:0] half;
        bit          pend;
        half = '0;
        pend = 1'b0;
        expW.delete();
        foreach (sentTok[i]) begin
            if (expW.size() >= limit) break;
            if (pend) begin
                if (expW.size() < cap) expW.push_back({sentTok[i], half});
                pend = 1'b0;
            end else begin
                half = sentTok[i];
                pend = 1'b1;
            end
        end
        if (pend && PAD_EN && expW.size() < cap) expW.push_back({PAD_TOKEN, half});
    endfunction

    task automatic compareWords(input string tag, input bit useL);
        int          n;
        logic [31:0] w;
        n = useL ? gotL.size() : gotB.size();
        checkOutput({tag, "_count"}, 32'(n), 32'(expW.size()));
        foreach (expW[i]) begin
            if (i < n) w = useL ? gotL[i] : gotB[i];
            else       w = 'x;
            checkOutput($sformatf("%s_word%0d", tag, i), w, expW[i]);
        end
    endtask

    task automatic waitDone(input bit useL);
        int cyc;
        cyc = 0;
        while (!(useL ? doneL : doneB) && cyc < 400) begin
            applyStimulus(16'h0, 1'b0, 1'b0, 1'b0);
            cyc++;
        end
        checkOutput(useL ? "done_wait_lim" : "done_wait", 32'(useL ? doneL : doneB), 32'd1);
    endtask

    task automatic beginCapture();
        gotB.delete();
        gotL.delete();
        sentTok.delete();
        applyStimulus(16'h0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int n;
        core_rst  = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        tok       = 16'h0;
        tokValid  = 1'b0;
        readyB    = 1'b1;
        randReady = 1'b0;
        repeat (3) @(posedge core_clk);
        #1;
        core_rst = 1'b0;

        checkOutput("rst_mem_valid", 32'(ifcB.mem_valid), 32'd0);
        checkOutput("rst_mem_data",  ifcB.mem_data,       32'd0);
        checkOutput("rst_words",     32'(wordsB),         32'd0);
        checkOutput("rst_overflow",  32'(overflowB),      32'd0);
        checkOutput("rst_busy",      32'(busyB),          32'd0);
        checkOutput("rst_done",      32'(doneB),          32'd0);
        tick();

        $display("[TB] basic pack");
        beginCapture();
        checkOutput("basic_busy", 32'(busyB), 32'd1);
        applyStimulus(16'h0001, 1'b1, 1'b0, 1'b0);
        applyStimulus(16'h8005, 1'b1, 1'b0, 1'b0);
        checkOutput("basic_lat_valid", 32'(ifcB.mem_valid), 32'd1);
        checkOutput("basic_lat_data",  ifcB.mem_data,       32'h80050001);
        applyStimulus(16'h0002, 1'b1, 1'b0, 1'b0);
        applyStimulus(16'h8003, 1'b1, 1'b0, 1'b0);
        applyStimulus(16'h0, 1'b0, 1'b0, 1'b1);
        waitDone(1'b0);
        buildModel(BIG, BIG);
        compareWords("basic", 1'b0);
        checkOutput("basic_words", 32'(wordsB), 32'd2);

        $display("[TB] random stream with random backpressure");
        randReady = 1'b1;
        beginCapture();
        n = 2 * $urandom_range(4, 10) + 1;
        for (int i = 0; i < n; i++) begin
            applyStimulus(16'($urandom), 1'b1, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) applyStimulus(16'h0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(16'h0, 1'b0, 1'b0, 1'b1);
        waitDone(1'b0);
        randReady = 1'b0;
        readyB    = 1'b1;
        buildModel(BIG, BIG);
        compareWords("rand", 1'b0);
        checkOutput("rand_words",    32'(wordsB),    32'(expW.size()));
        checkOutput("rand_overflow", 32'(overflowB), 32'd0);

        $display("[TB] flush with odd token count");
        beginCapture();
        for (int i = 0; i < 3; i++) applyStimulus(16'($urandom), 1'b1, 1'b0, 1'b0);
        applyStimulus(16'h0, 1'b0, 1'b0, 1'b1);
        waitDone(1'b0);
        buildModel(BIG, BIG);
        compareWords("pad", 1'b0);
        checkOutput("pad_words", 32'(wordsB), PAD_EN ? 32'd2 : 32'd1);

        $display("[TB] start in RUN, stop with second token");
        beginCapture();
        applyStimulus(16'h1111, 1'b1, 1'b0, 1'b0);
        applyStimulus(16'h8222, 1'b1, 1'b0, 1'b0);
        applyStimulus(16'h0333, 1'b1, 1'b0, 1'b0);
        checkOutput("edge_words_before", 32'(wordsB), 32'd1);
        applyStimulus(16'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("edge_start_words", 32'(wordsB), 32'd1);
        checkOutput("edge_start_busy",  32'(busyB),  32'd1);
        checkOutput("edge_start_done",  32'(doneB),  32'd0);
        applyStimulus(16'h8444, 1'b1, 1'b0, 1'b1);
        waitDone(1'b0);
        buildModel(BIG, BIG);
        compareWords("edge", 1'b0);
        checkOutput("edge_words", 32'(wordsB), 32'd2);

        $display("[TB] word limit");
        beginCapture();
        for (int i = 0; i < 10; i++) applyStimulus(16'($urandom), 1'b1, 1'b0, 1'b0);
        waitDone(1'b1);
        buildModel(int'(LIM), BIG);
        compareWords("limit", 1'b1);
        checkOutput("limit_words",    32'(wordsL),    32'(LIM));
        checkOutput("limit_overflow", 32'(overflowL), 32'd0);
        checkOutput("limit_big_busy", 32'(busyB),     32'd1);
        applyStimulus(16'h0, 1'b0, 1'b0, 1'b1);
        waitDone(1'b0);

        $display("[TB] backpressure and overflow");
        readyB = 1'b0;
        beginCapture();
        for (int i = 0; i < 2 * DEPTH + 2; i++) applyStimulus(16'($urandom), 1'b1, 1'b0, 1'b0);
        buildModel(BIG, DEPTH);
        checkOutput("bp_overflow", 32'(overflowB),      32'd1);
        checkOutput("bp_words",    32'(wordsB),         32'(DEPTH));
        checkOutput("bp_valid",    32'(ifcB.mem_valid), 32'd1);
        checkOutput("bp_head",     ifcB.mem_data,       expW[0]);
        applyStimulus(16'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_head_hold", ifcB.mem_data, expW[0]);
        applyStimulus(16'h0, 1'b0, 1'b0, 1'b1);
        readyB = 1'b1;
        waitDone(1'b0);
        compareWords("bp", 1'b0);

        $display("[TB] restart from DONE and asynchronous reset");
        beginCapture();
        checkOutput("restart_words",    32'(wordsB),    32'd0);
        checkOutput("restart_overflow", 32'(overflowB), 32'd0);
        checkOutput("restart_busy",     32'(busyB),     32'd1);
        checkOutput("restart_done",     32'(doneB),     32'd0);
        readyB = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(16'($urandom), 1'b1, 1'b0, 1'b0);
        checkOutput("queued_words", 32'(wordsB),         32'd3);
        checkOutput("queued_valid", 32'(ifcB.mem_valid), 32'd1);
        #2;
        core_rst = 1'b1;
        #1;
        checkOutput("arst_mem_valid", 32'(ifcB.mem_valid), 32'd0);
        checkOutput("arst_words",     32'(wordsB),         32'd0);
        checkOutput("arst_busy",      32'(busyB),          32'd0);
        checkOutput("arst_done",      32'(doneB),          32'd0);
        checkOutput("arst_lim_busy",  32'(busyL),          32'd0);
        tick();
        core_rst = 1'b0;
        readyB   = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
